active_list_ctrl: RTL and testbench
===================================

# active_list_ctrl

In-order commit controller for the renamed pipeline. It allocates an active-list entry per instruction at rename and records completion from the MEM→WB register's `wb_reg_out` / `active_list_index_out`. It retires completed entries in program order, returning superseded physical registers to the free list. On flush it walks squashed entries youngest-first so the rename map and free list can be restored.

## Interface
- `REG_ADDR_WIDTH`, 5, virtual/physical register address width
- `FREE_LIST_WIDTH`, 3, entry index width; depth DEPTH = 2^FREE_LIST_WIDTH (8)

Ports:
- `clk` in 1: single clock; all state updates on its rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `flush` in 1: squash all uncommitted entries
- `alloc_valid` in 1: rename stage requests an entry
- `alloc_has_dest` in 1: instruction writes a register
- `alloc_virtual_addr` in REG_ADDR_WIDTH: architectural destination
- `alloc_physical_addr` in REG_ADDR_WIDTH: newly mapped physical register
- `alloc_old_physical_addr` in REG_ADDR_WIDTH: previous mapping of that destination
- `alloc_ready` out 1: allocation accepted this cycle (combinational)
- `alloc_index` out FREE_LIST_WIDTH: index given to the allocating instruction (combinational, = tail)
- `wb_valid` in 1: completion strobe from MEM→WB
- `wb_index` in FREE_LIST_WIDTH: completing entry
- `commit_valid` out 1: one entry retired (registered)
- `commit_virtual_addr` out REG_ADDR_WIDTH: retired entry's virtual destination (registered)
- `commit_physical_addr` out REG_ADDR_WIDTH: retired entry's physical destination (registered)
- `free_valid` out 1: free-list return (registered)
- `free_physical_addr` out REG_ADDR_WIDTH: retired entry's old physical register (registered)
- `squash_valid` out 1: one squashed entry reported (registered)
- `squash_virtual_addr` out REG_ADDR_WIDTH: map entry to restore (registered)
- `squash_old_physical_addr` out REG_ADDR_WIDTH: mapping to restore (registered)
- `squash_physical_addr` out REG_ADDR_WIDTH: register returned to free list (registered)
- `busy` out 1: walk in progress
- `count` out FREE_LIST_WIDTH+1: occupied entries

## Operation
- Circular buffer; head/tail pointers FREE_LIST_WIDTH+1 bits wide.
  - Empty: head == tail.
  - Full: low bits equal and MSBs differ.
  - Pointers wrap modulo 2·DEPTH.
  - `count` = tail − head, modulo 2^(FREE_LIST_WIDTH+1).
- Per-entry state: valid, done, has_dest, virtual, physical, old_physical.
- States:
  - IDLE: normal operation.
  - WALK: squash sequencing.
- `alloc_ready` = IDLE && !full && !flush.
  - Accepted allocation writes the entry at tail with done=0, then tail+1.
- `wb_valid` in IDLE sets done[wb_index] if that entry is valid; otherwise the strobe is ignored.
- Commit (IDLE, !flush): if the head entry is valid && done:
  - Pulse `commit_valid` with its addresses; head+1, entry invalidated.
  - `free_valid` with old_physical only if has_dest.
  - Maximum one commit per cycle.
- Alloc, completion and commit may coincide in one cycle; all take effect.
  - Full with simultaneous commit: allocation is still refused.
- Flush in IDLE, empty: no effect.
- Flush in IDLE, non-empty: go to WALK.
  - Allocation, completion and commit are suppressed in the flush cycle.
- WALK, one entry per cycle:
  - tail−1 is reported as squashed. `squash_valid` pulses only for has_dest entries; walk cycles still consume non-dest entries.
  - The entry is invalidated and tail decrements.
  - When tail == head after the decrement, return to IDLE.
- During WALK:
  - `busy`=1, `alloc_ready`=0.
  - `wb_valid` ignored; commit suppressed.
  - `flush` ignored.
- Reset mid-walk: abort to IDLE, empty.

## Timing
- Reset:
  - All outputs 0 (alloc_ready 1 once rst_n is high and not flushed).
  - head=tail=0, all valid/done 0, state IDLE.
- Completion-to-commit latency:
  - done is written on the wb edge; the commit decision uses the registered done bit.
  - `commit_valid` is high in the cycle after the edge that commits, i.e. 2 cycles after the wb strobe cycle.
- Alloc→index: `alloc_index` is valid in the request cycle.
- Flush of N entries:
  - `busy` high for exactly N cycles, starting the cycle after flush.
  - Squash outputs lag walk state by one registered cycle.
- Pulse outputs (commit/free/squash *_valid) are single-cycle; data holds its last value when not valid.

## Structure
- Shared package:
  - state enum {IDLE, WALK}
  - DEPTH = 1 << FREE_LIST_WIDTH
  - entry record typedef (valid, done, has_dest, virtual, physical, old_physical)
- Entry storage is a flat register array inside the block; no sub-module needed.
- Pointer full/empty logic may be factored into `active_list_ptr` if reused by the free list.

## Test plan
- Reset, alloc 3 entries (P8,P9,P10 over old P1,P2,P3), wb indices 2,0,1 → commits in order 0,1,2, free_physical 1,2,3, one per cycle.
- Alloc 8 → alloc_ready=0, count=8. Complete index 0 → commit in 2 cycles, alloc_ready returns; tail wraps to index 0 with pointer MSB toggled.
- Alloc with alloc_has_dest=0, complete → commit_valid=1, free_valid=0.
- 5 entries allocated, flush → busy 5 cycles; squash reported for indices 4,3,2,1,0 with matching old_physical; count=0; wb_valid and flush during walk have no effect.
- wb_valid on an invalid index → no state change. wb on head in the same cycle as an alloc into a different entry → both take effect.
- rst_n low mid-walk → all outputs 0, count=0, IDLE immediately (asynchronously).

Source files
------------

// File: rtl/active_list_ctrl_pkg.sv
// Shared types and constants for the in-order active list (reorder buffer).
// Entry record widths follow the default address/index widths below.
package active_list_ctrl_pkg;

  localparam int AL_REG_W = 5;
  localparam int AL_IDX_W = 3;
  localparam int AL_DEPTH = 1 << AL_IDX_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } al_state_e;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                has_dest;
    logic [AL_REG_W-1:0] virt_addr;
    logic [AL_REG_W-1:0] phys_addr;
    logic [AL_REG_W-1:0] old_phys_addr;
  } al_entry_t;

endpackage

// File: rtl/active_list_ptr.sv
// Occupancy decode for a circular buffer with one extra wrap bit on each pointer.
module active_list_ptr #(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W:0] i_head,
  input  logic [IDX_W:0] i_tail,
  output logic           o_empty,
  output logic           o_full,
  output logic [IDX_W:0] o_count
);

  assign o_empty = (i_head == i_tail);
  assign o_full  = (i_head[IDX_W-1:0] == i_tail[IDX_W-1:0]) && (i_head[IDX_W] != i_tail[IDX_W]);
  assign o_count = i_tail - i_head;

endmodule

// File: rtl/active_list_ctrl.sv
// In-order commit controller: allocates at rename, marks completion from writeback,
// retires from the head, and on flush walks squashed entries youngest-first.
module active_list_ctrl
  import active_list_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = AL_REG_W,
  parameter int FREE_LIST_WIDTH = AL_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        alloc_valid,
  input  logic                        alloc_has_dest,
  input  logic [REG_ADDR_WIDTH-1:0]   alloc_virtual_addr,
  input  logic [REG_ADDR_WIDTH-1:0]   alloc_physical_addr,
  input  logic [REG_ADDR_WIDTH-1:0]   alloc_old_physical_addr,
  output logic                        alloc_ready,
  output logic [FREE_LIST_WIDTH-1:0]  alloc_index,
  input  logic                        wb_valid,
  input  logic [FREE_LIST_WIDTH-1:0]  wb_index,
  output logic                        commit_valid,
  output logic [REG_ADDR_WIDTH-1:0]   commit_virtual_addr,
  output logic [REG_ADDR_WIDTH-1:0]   commit_physical_addr,
  output logic                        free_valid,
  output logic [REG_ADDR_WIDTH-1:0]   free_physical_addr,
  output logic                        squash_valid,
  output logic [REG_ADDR_WIDTH-1:0]   squash_virtual_addr,
  output logic [REG_ADDR_WIDTH-1:0]   squash_old_physical_addr,
  output logic [REG_ADDR_WIDTH-1:0]   squash_physical_addr,
  output logic                        busy,
  output logic [FREE_LIST_WIDTH:0]    count
);

  localparam int DEPTH = 1 << FREE_LIST_WIDTH;
  localparam int PTR_W = FREE_LIST_WIDTH + 1;

  al_state_e                     r_state;
  al_state_e                     w_next_state;
  al_entry_t [DEPTH-1:0]         r_entries;
  logic [PTR_W-1:0]              r_head;
  logic [PTR_W-1:0]              r_tail;
  logic [PTR_W-1:0]              w_last_ptr;
  logic [FREE_LIST_WIDTH-1:0]    w_head_idx;
  logic [FREE_LIST_WIDTH-1:0]    w_tail_idx;
  logic [FREE_LIST_WIDTH-1:0]    w_last_idx;
  al_entry_t                     w_head_ent;
  al_entry_t                     w_last_ent;
  logic                          w_empty;
  logic                          w_full;
  logic [PTR_W-1:0]              w_count;
  logic                          w_can_alloc;
  logic                          w_alloc_fire;
  logic                          w_wb_fire;
  logic                          w_commit_fire;
  logic                          w_walk_step;

  logic                          r_commit_valid;
  logic [REG_ADDR_WIDTH-1:0]     r_commit_virt;
  logic [REG_ADDR_WIDTH-1:0]     r_commit_phys;
  logic                          r_free_valid;
  logic [REG_ADDR_WIDTH-1:0]     r_free_phys;
  logic                          r_squash_valid;
  logic [REG_ADDR_WIDTH-1:0]     r_squash_virt;
  logic [REG_ADDR_WIDTH-1:0]     r_squash_old_phys;
  logic [REG_ADDR_WIDTH-1:0]     r_squash_phys;

  active_list_ptr #(.IDX_W(FREE_LIST_WIDTH)) u_ptr (
    .i_head  (r_head),
    .i_tail  (r_tail),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign w_head_idx = r_head[FREE_LIST_WIDTH-1:0];
  assign w_tail_idx = r_tail[FREE_LIST_WIDTH-1:0];
  assign w_last_ptr = r_tail - PTR_W'(1);
  assign w_last_idx = w_last_ptr[FREE_LIST_WIDTH-1:0];
  assign w_head_ent = r_entries[w_head_idx];
  assign w_last_ent = r_entries[w_last_idx];

  // Holding reset keeps alloc_ready low so rename cannot see a phantom grant.
  assign w_can_alloc = (r_state == ST_IDLE) && !w_full && !flush;
  assign alloc_ready = rst_n && w_can_alloc;
  assign alloc_index = w_tail_idx;
  assign busy        = (r_state == ST_WALK);
  assign count       = w_count;

  always_comb begin
    w_next_state  = r_state;
    w_alloc_fire  = 1'b0;
    w_wb_fire     = 1'b0;
    w_commit_fire = 1'b0;
    w_walk_step   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flush) begin
          if (!w_empty) w_next_state = ST_WALK;
        end else begin
          w_alloc_fire  = alloc_valid && w_can_alloc;
          w_wb_fire     = wb_valid && r_entries[wb_index].valid;
          w_commit_fire = w_head_ent.valid && w_head_ent.done;
        end
      end
      ST_WALK: begin
        w_walk_step = 1'b1;
        if (w_last_ptr == r_head) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entries         <= '0;
      r_head            <= '0;
      r_tail            <= '0;
      r_commit_valid    <= 1'b0;
      r_commit_virt     <= '0;
      r_commit_phys     <= '0;
      r_free_valid      <= 1'b0;
      r_free_phys       <= '0;
      r_squash_valid    <= 1'b0;
      r_squash_virt     <= '0;
      r_squash_old_phys <= '0;
      r_squash_phys     <= '0;
    end else begin
      r_commit_valid <= 1'b0;
      r_free_valid   <= 1'b0;
      r_squash_valid <= 1'b0;

      if (w_wb_fire) r_entries[wb_index].done <= 1'b1;

      if (w_alloc_fire) begin
        r_entries[w_tail_idx] <= '{valid: 1'b1, done: 1'b0, has_dest: alloc_has_dest,
                                   virt_addr: alloc_virtual_addr,
                                   phys_addr: alloc_physical_addr,
                                   old_phys_addr: alloc_old_physical_addr};
        r_tail <= r_tail + PTR_W'(1);
      end

      // Head and tail slots differ whenever an alloc is accepted, so these never collide.
      if (w_commit_fire) begin
        r_entries[w_head_idx].valid <= 1'b0;
        r_entries[w_head_idx].done  <= 1'b0;
        r_head         <= r_head + PTR_W'(1);
        r_commit_valid <= 1'b1;
        r_commit_virt  <= w_head_ent.virt_addr;
        r_commit_phys  <= w_head_ent.phys_addr;
        if (w_head_ent.has_dest) begin
          r_free_valid <= 1'b1;
          r_free_phys  <= w_head_ent.old_phys_addr;
        end
      end

      if (w_walk_step) begin
        r_entries[w_last_idx].valid <= 1'b0;
        r_entries[w_last_idx].done  <= 1'b0;
        r_tail <= w_last_ptr;
        if (w_last_ent.has_dest) begin
          r_squash_valid    <= 1'b1;
          r_squash_virt     <= w_last_ent.virt_addr;
          r_squash_old_phys <= w_last_ent.old_phys_addr;
          r_squash_phys     <= w_last_ent.phys_addr;
        end
      end
    end
  end

  assign commit_valid             = r_commit_valid;
  assign commit_virtual_addr      = r_commit_virt;
  assign commit_physical_addr     = r_commit_phys;
  assign free_valid               = r_free_valid;
  assign free_physical_addr       = r_free_phys;
  assign squash_valid             = r_squash_valid;
  assign squash_virtual_addr      = r_squash_virt;
  assign squash_old_physical_addr = r_squash_old_phys;
  assign squash_physical_addr     = r_squash_phys;

endmodule

// File: tb/tb_active_list_ctrl.sv
// Bench for active_list_ctrl: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based program-order model.
module tb_active_list_ctrl;

  localparam int RW    = 5;
  localparam int IW    = 3;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          flush, alloc_valid, alloc_has_dest, wb_valid;
  logic [RW-1:0] alloc_virtual_addr, alloc_physical_addr, alloc_old_physical_addr;
  logic [IW-1:0] wb_index, alloc_index;
  logic          alloc_ready, commit_valid, free_valid, squash_valid, busy;
  logic [RW-1:0] commit_virtual_addr, commit_physical_addr, free_physical_addr;
  logic [RW-1:0] squash_virtual_addr, squash_old_physical_addr, squash_physical_addr;
  logic [IW:0]   count;

  active_list_ctrl #(.REG_ADDR_WIDTH(RW), .FREE_LIST_WIDTH(IW)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .flush                    (flush),
    .alloc_valid              (alloc_valid),
    .alloc_has_dest           (alloc_has_dest),
    .alloc_virtual_addr       (alloc_virtual_addr),
    .alloc_physical_addr      (alloc_physical_addr),
    .alloc_old_physical_addr  (alloc_old_physical_addr),
    .alloc_ready              (alloc_ready),
    .alloc_index              (alloc_index),
    .wb_valid                 (wb_valid),
    .wb_index                 (wb_index),
    .commit_valid             (commit_valid),
    .commit_virtual_addr      (commit_virtual_addr),
    .commit_physical_addr     (commit_physical_addr),
    .free_valid               (free_valid),
    .free_physical_addr       (free_physical_addr),
    .squash_valid             (squash_valid),
    .squash_virtual_addr      (squash_virtual_addr),
    .squash_old_physical_addr (squash_old_physical_addr),
    .squash_physical_addr     (squash_physical_addr),
    .busy                     (busy),
    .count                    (count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [RW-1:0] va;
    logic [RW-1:0] pa;
    logic [RW-1:0] oa;
    logic          hd;
    logic          dn;
  } m_ent_t;

  typedef struct packed {
    logic          cv;
    logic [RW-1:0] cva;
    logic [RW-1:0] cpa;
    logic          fv;
    logic [RW-1:0] fpa;
    logic          sv;
    logic [RW-1:0] sva;
    logic [RW-1:0] soa;
    logic [RW-1:0] spa;
  } pulse_t;

  localparam int PW = $bits(pulse_t);

  m_ent_t        m_q[$];      // live entries, oldest first
  int            m_head;      // slot index of the oldest entry
  bit            m_walk;
  logic [PW-1:0] exp_q[$];

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_head = 0;
    m_walk = 0;
  endtask

  task automatic model_step();
    pulse_t p;
    m_ent_t e;
    bit     room;
    bit     do_commit;
    int     pos;
    p    = '0;
    room = (m_q.size() < DEPTH);
    if (m_walk) begin
      e = m_q.pop_back();
      if (e.hd) begin
        p.sv = 1'b1; p.sva = e.va; p.soa = e.oa; p.spa = e.pa;
      end
      if (m_q.size() == 0) m_walk = 0;
    end else if (flush) begin
      if (m_q.size() > 0) m_walk = 1;
    end else begin
      do_commit = (m_q.size() > 0) && m_q[0].dn;
      if (wb_valid) begin
        pos = (int'(wb_index) - m_head + DEPTH) % DEPTH;
        if (pos < m_q.size()) m_q[pos].dn = 1'b1;
      end
      if (do_commit) begin
        e = m_q.pop_front();
        m_head = (m_head + 1) % DEPTH;
        p.cv = 1'b1; p.cva = e.va; p.cpa = e.pa;
        if (e.hd) begin
          p.fv = 1'b1; p.fpa = e.oa;
        end
      end
      if (alloc_valid && room) begin
        e.va = alloc_virtual_addr; e.pa = alloc_physical_addr;
        e.oa = alloc_old_physical_addr; e.hd = alloc_has_dest; e.dn = 1'b0;
        m_q.push_back(e);
      end
    end
    exp_q.push_back(p);
  endtask

  task automatic check_comb();
    chk("alloc_ready", alloc_ready, !m_walk && (m_q.size() < DEPTH) && !flush);
    chk("alloc_index", alloc_index, (m_head + m_q.size()) % DEPTH);
    chk("count", count, m_q.size());
    chk("busy", busy, m_walk);
  endtask

  task automatic check_pulse();
    pulse_t p;
    p = exp_q.pop_front();
    chk("commit_valid", commit_valid, p.cv);
    if (p.cv) begin
      chk("commit_virtual_addr", commit_virtual_addr, p.cva);
      chk("commit_physical_addr", commit_physical_addr, p.cpa);
    end
    chk("free_valid", free_valid, p.fv);
    if (p.fv) chk("free_physical_addr", free_physical_addr, p.fpa);
    chk("squash_valid", squash_valid, p.sv);
    if (p.sv) begin
      chk("squash_virtual_addr", squash_virtual_addr, p.sva);
      chk("squash_old_physical_addr", squash_old_physical_addr, p.soa);
      chk("squash_physical_addr", squash_physical_addr, p.spa);
    end
  endtask

  // Inputs are driven at posedge+1; comb outputs sampled at +2, pulses at next posedge+1.
  task automatic cycle();
    #1;
    check_comb();
    model_step();
    @(posedge clk);
    #1;
    check_pulse();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush = 0; alloc_valid = 0; alloc_has_dest = 0; wb_valid = 0; wb_index = '0;
    alloc_virtual_addr = '0; alloc_physical_addr = '0; alloc_old_physical_addr = '0;
  endtask

  task automatic drive_alloc(input logic hd);
    alloc_valid             = 1;
    alloc_has_dest          = hd;
    alloc_virtual_addr      = RW'($urandom_range(0, 31));
    alloc_physical_addr     = RW'($urandom_range(0, 31));
    alloc_old_physical_addr = RW'($urandom_range(0, 31));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_alloc_ready"}, alloc_ready, 0);
    chk({tag, "_commit_valid"}, commit_valid, 0);
    chk({tag, "_free_valid"}, free_valid, 0);
    chk({tag, "_squash_valid"}, squash_valid, 0);
    chk({tag, "_squash_addrs"}, {squash_virtual_addr, squash_old_physical_addr, squash_physical_addr}, 0);
    chk({tag, "_commit_addrs"}, {commit_virtual_addr, commit_physical_addr, free_physical_addr}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_alloc_index"}, alloc_index, 0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          fl, av, hd;
    logic [RW-1:0] va, pa, oa;
    logic          wv;
    logic [IW-1:0] wi;
    logic          e_rdy;
    logic [IW-1:0] e_idx;
    logic [IW:0]   e_cnt;
    logic          e_cv;
    logic [RW-1:0] e_cpa;
    logic          e_fv;
    logic [RW-1:0] e_fpa;
  } vec_t;

  vec_t vt[13];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int busy_n;
    #3;
    // fl av hd va pa oa wv wi | rdy idx cnt | cv cpa fv fpa
    vt[0]  = '{0,1,1, 5'd1, 5'd8, 5'd1, 0,3'd0, 1,3'd0,4'd0, 0,5'd0, 0,5'd0};
    vt[1]  = '{0,1,1, 5'd2, 5'd9, 5'd2, 0,3'd0, 1,3'd1,4'd1, 0,5'd0, 0,5'd0};
    vt[2]  = '{0,1,1, 5'd3,5'd10, 5'd3, 0,3'd0, 1,3'd2,4'd2, 0,5'd0, 0,5'd0};
    vt[3]  = '{0,0,0, 5'd0, 5'd0, 5'd0, 1,3'd2, 1,3'd3,4'd3, 0,5'd0, 0,5'd0};
    vt[4]  = '{0,0,0, 5'd0, 5'd0, 5'd0, 1,3'd0, 1,3'd3,4'd3, 0,5'd0, 0,5'd0};
    vt[5]  = '{0,0,0, 5'd0, 5'd0, 5'd0, 1,3'd1, 1,3'd3,4'd3, 1,5'd8, 1,5'd1};
    vt[6]  = '{0,0,0, 5'd0, 5'd0, 5'd0, 0,3'd0, 1,3'd3,4'd2, 1,5'd9, 1,5'd2};
    vt[7]  = '{0,0,0, 5'd0, 5'd0, 5'd0, 0,3'd0, 1,3'd3,4'd1, 1,5'd10,1,5'd3};
    vt[8]  = '{0,0,0, 5'd0, 5'd0, 5'd0, 0,3'd0, 1,3'd3,4'd0, 0,5'd0, 0,5'd0};
    vt[9]  = '{0,1,0, 5'd4,5'd11, 5'd4, 0,3'd0, 1,3'd3,4'd0, 0,5'd0, 0,5'd0};
    vt[10] = '{0,0,0, 5'd0, 5'd0, 5'd0, 1,3'd3, 1,3'd4,4'd1, 0,5'd0, 0,5'd0};
    vt[11] = '{0,0,0, 5'd0, 5'd0, 5'd0, 0,3'd0, 1,3'd4,4'd1, 1,5'd11,0,5'd0};
    vt[12] = '{0,0,0, 5'd0, 5'd0, 5'd0, 0,3'd0, 1,3'd4,4'd0, 0,5'd0, 0,5'd0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      flush = vt[i].fl; alloc_valid = vt[i].av; alloc_has_dest = vt[i].hd;
      alloc_virtual_addr = vt[i].va; alloc_physical_addr = vt[i].pa;
      alloc_old_physical_addr = vt[i].oa; wb_valid = vt[i].wv; wb_index = vt[i].wi;
      #1;
      chk("vec_alloc_ready", alloc_ready, vt[i].e_rdy);
      chk("vec_alloc_index", alloc_index, vt[i].e_idx);
      chk("vec_count", count, vt[i].e_cnt);
      @(posedge clk);
      #1;
      chk("vec_commit_valid", commit_valid, vt[i].e_cv);
      if (vt[i].e_cv) chk("vec_commit_phys", commit_physical_addr, vt[i].e_cpa);
      chk("vec_free_valid", free_valid, vt[i].e_fv);
      if (vt[i].e_fv) chk("vec_free_phys", free_physical_addr, vt[i].e_fpa);
    end

    // Fill to full, refused alloc while full (also with a simultaneous commit), then wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_idle(); drive_alloc(1); cycle();
    end
    drive_alloc(1); wb_valid = 1; wb_index = 3'd0;
    #1;
    chk("full_count", count, 8);
    chk("full_ready", alloc_ready, 0);
    cycle();
    drive_alloc(1); wb_valid = 0;
    cycle();
    drive_alloc(1);
    #1;
    chk("wrap_ready", alloc_ready, 1);
    chk("wrap_index", alloc_index, 0);
    cycle();
    for (int k = 0; k < DEPTH; k++) begin
      drive_idle(); wb_valid = 1; wb_index = IW'(k); cycle();
    end
    drive_idle();
    repeat (12) cycle();
    chk("drain_count", count, 0);

    // Flush of five entries; wb and flush during the walk must be ignored.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_idle(); drive_alloc(1); cycle();
    end
    drive_idle(); wb_valid = 1; wb_index = 3'd0; flush = 1;
    cycle();
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      drive_idle();
      wb_valid = 1; wb_index = IW'($urandom_range(0, 7)); flush = 1'($urandom_range(0, 1));
      #1;
      if (busy) busy_n++;
      cycle();
    end
    chk("walk_busy_cycles", busy_n, 5);
    chk("walk_count", count, 0);

    // Completion on an invalid slot, then wb on head alongside an alloc elsewhere.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_idle(); drive_alloc(i[0]); cycle();
    end
    drive_idle(); wb_valid = 1; wb_index = 3'd5; cycle();
    drive_idle(); repeat (3) cycle();
    drive_idle(); drive_alloc(1); wb_valid = 1; wb_index = 3'd0; cycle();
    drive_idle(); repeat (3) cycle();
    chk("wb_head_count", count, 2);

    // Asynchronous reset in the middle of a walk.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_idle(); drive_alloc(1); cycle();
    end
    drive_idle(); flush = 1; cycle();
    drive_idle(); repeat (2) cycle();
    #1;
    rst_n = 0;
    #1;
    check_all_zero("midwalk");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    drive_idle(); drive_alloc(1); cycle();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive_idle();
      flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) != 0) drive_alloc($urandom_range(0, 3) != 0);
      wb_valid = 1'($urandom_range(0, 1));
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
        wb_index = IW'((m_head + $urandom_range(0, m_q.size() - 1)) % DEPTH);
      else
        wb_index = IW'($urandom_range(0, 7));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
